// File: rtl/sprite_arbiter_pkg.sv
// Shared types and helpers for the sprite arbiter: object geometry, scan FSM states,
// default parameter values.
package sprite_arbiter_pkg;

  localparam int unsigned NumObjDefault = 8;
  localparam int unsigned AddrWDefault  = 18;
  localparam int unsigned CoordW        = 10;
  localparam int unsigned ColourW       = 12;
  localparam logic [ColourW-1:0] TransparentDefault = 12'hF0F;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } scan_state_e;

  typedef struct packed {
    logic              en;
    logic [CoordW-1:0] posx;
    logic [CoordW-1:0] posy;
    logic [CoordW-1:0] width;
    logic [CoordW-1:0] height;
  } obj_geom_t;

  // pos <= v < pos + size, with an 11-bit end so spans near 1023 never wrap.
  function automatic logic in_span(input logic [CoordW-1:0] pos,
                                   input logic [CoordW-1:0] size,
                                   input logic [CoordW-1:0] v);
    logic [CoordW:0] span_end;
    span_end = {1'b0, pos} + {1'b0, size};
    return (size != '0) && (v >= pos) && ({1'b0, v} < span_end);
  endfunction

endpackage

// File: rtl/sprite_arbiter_if.sv
// Bus between game logic / VGA timing / sprite ROM and the sprite arbiter.
interface sprite_arbiter_if #(
  parameter int unsigned NUM_OBJ = 8,
  parameter int unsigned ADDR_W  = 18
);
  localparam int unsigned IdxW = $clog2(NUM_OBJ);

  logic            cfg_we;
  logic [IdxW-1:0] cfg_idx;
  logic            cfg_en;
  logic [9:0]      cfg_posx;
  logic [9:0]      cfg_posy;
  logic [9:0]      cfg_width;
  logic [9:0]      cfg_height;
  logic [ADDR_W-1:0] cfg_addr;
  logic            frame_start;
  logic            line_start;
  logic [9:0]      line_row;
  logic [9:0]      col;
  logic [9:0]      row;
  logic            video_on;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]     mem_data;
  logic [11:0]     vga_data;
  logic            hit;
  logic            scan_busy;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_posx, cfg_posy, cfg_width, cfg_height, cfg_addr,
    output frame_start, line_start, line_row, col, row, video_on, mem_data,
    input  mem_addr, vga_data, hit, scan_busy
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_posx, cfg_posy, cfg_width, cfg_height, cfg_addr,
    input  frame_start, line_start, line_row, col, row, video_on, mem_data,
    output mem_addr, vga_data, hit, scan_busy
  );
endinterface

// File: rtl/sprite_line_scan.sv
// Per-line scan of the active object table, one slot per cycle, into a double-buffered mask.
module sprite_line_scan
  import sprite_arbiter_pkg::*;
#(
  parameter int unsigned NUM_OBJ = NumObjDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_start_i,
  input  logic               frame_start_i,
  input  logic [CoordW-1:0]  line_row_i,
  input  obj_geom_t          tbl_i [NUM_OBJ],
  output logic [NUM_OBJ-1:0] line_mask_o,
  output logic               scan_busy_o
);
  localparam int unsigned IdxW = $clog2(NUM_OBJ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OBJ - 1);

  scan_state_e        state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NUM_OBJ-1:0] build_q, build_d;
  logic [NUM_OBJ-1:0] mask_q, mask_d;
  logic [CoordW-1:0]  row_q, row_d;
  logic               slot_hit;

  assign slot_hit = tbl_i[idx_q].en && (tbl_i[idx_q].width != '0) &&
                    in_span(tbl_i[idx_q].posy, tbl_i[idx_q].height, row_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    build_d = build_q;
    mask_d  = mask_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (line_start_i) begin
          state_d = StScan;
          idx_d   = '0;
          build_d = '0;
          row_d   = line_row_i;
        end
      end
      StScan: begin
        if (frame_start_i) begin
          state_d = StIdle;
        end else if (line_start_i) begin
          idx_d   = '0;
          build_d = '0;
          row_d   = line_row_i;
        end else begin
          build_d[idx_q] = slot_hit;
          if (idx_q == LastIdx) state_d = StDone;
          else                  idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        mask_d  = build_q;
        state_d = StIdle;
        // A line_start arriving in the copy cycle must not be dropped.
        if (line_start_i) begin
          state_d = StScan;
          idx_d   = '0;
          build_d = '0;
          row_d   = line_row_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      build_q <= '0;
      mask_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      build_q <= build_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
    end
  end

  assign line_mask_o = mask_q;
  assign scan_busy_o = (state_q == StScan);

endmodule

// File: rtl/sprite_arbiter.sv
// One sprite ROM shared by NUM_OBJ objects: shadow/active object tables, line scan and a
// 3-stage pixel pipeline picking the lowest-index covering object.
module sprite_arbiter
  import sprite_arbiter_pkg::*;
#(
  parameter int unsigned         NUM_OBJ     = NumObjDefault,
  parameter int unsigned         ADDR_W      = AddrWDefault,
  parameter logic [ColourW-1:0]  TRANSPARENT = TransparentDefault
) (
  input logic             clk,
  input logic             rst_n,
  sprite_arbiter_if.slave bus_io
);
  localparam int unsigned IdxW = $clog2(NUM_OBJ);

  obj_geom_t         shadow_q      [NUM_OBJ];
  logic [ADDR_W-1:0] shadow_addr_q [NUM_OBJ];
  obj_geom_t         active_q      [NUM_OBJ];
  logic [ADDR_W-1:0] active_addr_q [NUM_OBJ];

  logic [NUM_OBJ-1:0] line_mask;
  logic               win_valid;
  logic [IdxW-1:0]    win_id;
  logic               s0_valid_q, s1_valid_q, s2_valid_q;
  logic [IdxW-1:0]    s0_id_q;
  logic [CoordW-1:0]  s0_relx_q, s0_rely_q;
  logic [19:0]        prod;
  logic [ADDR_W-1:0]  addr_d, mem_addr_q;
  logic               opaque;

  // Commit reads the old shadow, so a same-cycle cfg write lands in the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_q[i]      <= '0;
        shadow_addr_q[i] <= '0;
        active_q[i]      <= '0;
        active_addr_q[i] <= '0;
      end
    end else begin
      if (bus_io.cfg_we) begin
        shadow_q[bus_io.cfg_idx] <= '{en:     bus_io.cfg_en,
                                      posx:   bus_io.cfg_posx,
                                      posy:   bus_io.cfg_posy,
                                      width:  bus_io.cfg_width,
                                      height: bus_io.cfg_height};
        shadow_addr_q[bus_io.cfg_idx] <= bus_io.cfg_addr;
      end
      if (bus_io.frame_start) begin
        active_q      <= shadow_q;
        active_addr_q <= shadow_addr_q;
      end
    end
  end

  sprite_line_scan #(
    .NUM_OBJ(NUM_OBJ)
  ) u_line_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start_i (bus_io.line_start),
    .frame_start_i(bus_io.frame_start),
    .line_row_i   (bus_io.line_row),
    .tbl_i        (active_q),
    .line_mask_o  (line_mask),
    .scan_busy_o  (bus_io.scan_busy)
  );

  // Descending walk so the lowest covering index is the last assignment.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (line_mask[i] && in_span(active_q[i].posx, active_q[i].width, bus_io.col)) begin
        win_valid = 1'b1;
        win_id    = IdxW'(i);
      end
    end
    win_valid = win_valid && bus_io.video_on;
  end

  assign prod   = 20'(s0_rely_q) * 20'(active_q[s0_id_q].width);
  assign addr_d = active_addr_q[s0_id_q] + ADDR_W'(prod) + ADDR_W'(s0_relx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_id_q    <= '0;
      s0_relx_q  <= '0;
      s0_rely_q  <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      s0_valid_q <= win_valid;
      if (win_valid) begin
        s0_id_q   <= win_id;
        s0_relx_q <= bus_io.col - active_q[win_id].posx;
        s0_rely_q <= bus_io.row - active_q[win_id].posy;
      end
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) mem_addr_q <= addr_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  // The ROM output register is the S2 register; colour keying is applied on its output.
  assign opaque          = s2_valid_q && (bus_io.mem_data != TRANSPARENT);
  assign bus_io.mem_addr = mem_addr_q;
  assign bus_io.vga_data = opaque ? bus_io.mem_data : 12'h000;
  assign bus_io.hit      = opaque;

endmodule

// File: tb/tb_sprite_arbiter.sv
// Scoreboard bench for sprite_arbiter with a behavioural 1-cycle-latency sprite ROM.
module tb_sprite_arbiter;
  localparam int unsigned NumObj = 8;
  localparam int unsigned AddrW  = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_arbiter_if #(.NUM_OBJ(NumObj), .ADDR_W(AddrW)) bus_if ();

  sprite_arbiter #(
    .NUM_OBJ    (NumObj),
    .ADDR_W     (AddrW),
    .TRANSPARENT(12'hF0F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus_if)
  );

  typedef struct {int due; logic [AddrW-1:0] addr;} addr_exp_t;
  typedef struct {int due; logic [11:0] vga; logic hit;} pix_exp_t;

  addr_exp_t aq[$];
  pix_exp_t  pq[$];
  addr_exp_t ae;
  pix_exp_t  pe;
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  logic [AddrW-1:0] transp_addr = '1;

  function automatic logic [11:0] rom_word(input logic [AddrW-1:0] a);
    if (a == transp_addr) return 12'hF0F;
    return a[11:0] + 12'h123;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus_if.mem_data <= rom_word(bus_if.mem_addr);
  end

  // Scoreboard: pop expectations when their pipeline slot comes due.
  always @(negedge clk) begin
    if (aq.size() != 0 && aq[0].due == cyc) begin
      ae = aq.pop_front();
      n_total++;
      if (bus_if.mem_addr !== ae.addr)
        $display("FAIL mem_addr cyc=%0d: got %h want %h", cyc, bus_if.mem_addr, ae.addr);
      else n_pass++;
    end
    if (pq.size() != 0 && pq[0].due == cyc) begin
      pe = pq.pop_front();
      n_total++;
      if (bus_if.vga_data !== pe.vga || bus_if.hit !== pe.hit)
        $display("FAIL pixel cyc=%0d: got vga=%h hit=%b want vga=%h hit=%b",
                 cyc, bus_if.vga_data, bus_if.hit, pe.vga, pe.hit);
      else n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int idx, input logic en, input int x, input int y,
                            input int w, input int h, input logic [AddrW-1:0] a,
                            input logic with_frame);
    tick();
    bus_if.cfg_we      = 1'b1;
    bus_if.cfg_idx     = 3'(idx);
    bus_if.cfg_en      = en;
    bus_if.cfg_posx    = 10'(x);
    bus_if.cfg_posy    = 10'(y);
    bus_if.cfg_width   = 10'(w);
    bus_if.cfg_height  = 10'(h);
    bus_if.cfg_addr    = a;
    bus_if.frame_start = with_frame;
    tick();
    bus_if.cfg_we      = 1'b0;
    bus_if.frame_start = 1'b0;
  endtask

  task automatic frame();
    tick();
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.frame_start = 1'b0;
  endtask

  task automatic scan(input int r);
    int k;
    tick();
    bus_if.line_start = 1'b1;
    bus_if.line_row   = 10'(r);
    tick();
    bus_if.line_start = 1'b0;
    k = 0;
    while (bus_if.scan_busy && k < 40) begin
      tick();
      k++;
    end
    n_total++;
    if (k >= 40) $display("FAIL scan_done row=%0d: busy after %0d cycles, want <40", r, k);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic px_obj(input int c, input int r, input logic [AddrW-1:0] a);
    logic [11:0] w;
    w = rom_word(a);
    tick();
    bus_if.col = 10'(c);
    bus_if.row = 10'(r);
    bus_if.video_on = 1'b1;
    aq.push_back('{cyc + 2, a});
    if (w == 12'hF0F) pq.push_back('{cyc + 3, 12'h000, 1'b0});
    else              pq.push_back('{cyc + 3, w, 1'b1});
  endtask

  task automatic px_none(input int c, input int r, input logic von);
    tick();
    bus_if.col = 10'(c);
    bus_if.row = 10'(r);
    bus_if.video_on = von;
    pq.push_back('{cyc + 3, 12'h000, 1'b0});
  endtask

  task automatic drain();
    tick();
    bus_if.video_on = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    n_total++;
    if (bus_if.vga_data !== 12'h000 || bus_if.hit !== 1'b0 || bus_if.mem_addr !== '0 ||
        bus_if.scan_busy !== 1'b0)
      $display("FAIL %s: got vga=%h hit=%b addr=%h busy=%b want all zero", tag,
               bus_if.vga_data, bus_if.hit, bus_if.mem_addr, bus_if.scan_busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus_if.cfg_we = 1'b0; bus_if.cfg_idx = '0; bus_if.cfg_en = 1'b0;
    bus_if.cfg_posx = '0; bus_if.cfg_posy = '0; bus_if.cfg_width = '0;
    bus_if.cfg_height = '0; bus_if.cfg_addr = '0; bus_if.frame_start = 1'b0;
    bus_if.line_start = 1'b0; bus_if.line_row = '0; bus_if.col = '0; bus_if.row = '0;
    bus_if.video_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    write_slot(0, 1'b1, 100, 50, 16, 8, 18'h400, 1'b0);
    frame();
    scan(50);
    px_obj(100, 50, 18'h400);
    px_obj(115, 50, 18'h40F);
    px_none(116, 50, 1'b1);
    px_none(99, 50, 1'b1);
    drain();
  endtask

  task automatic test_priority();
    write_slot(0, 1'b1, 10, 10, 8, 8, 18'h1000, 1'b0);
    write_slot(3, 1'b1, 12, 10, 8, 8, 18'h2000, 1'b0);
    frame();
    scan(10);
    px_obj(12, 10, 18'h1002);
    px_obj(17, 10, 18'h1007);
    px_obj(18, 10, 18'h2006);
    px_obj(19, 10, 18'h2007);
    drain();
  endtask

  task automatic test_transparent();
    transp_addr = 18'h3000;
    write_slot(2, 1'b1, 200, 20, 4, 4, 18'h3000, 1'b0);
    write_slot(5, 1'b1, 200, 20, 4, 4, 18'h5000, 1'b0);
    frame();
    scan(20);
    px_obj(200, 20, 18'h3000);
    px_obj(201, 20, 18'h3001);
    px_none(201, 20, 1'b0);
    drain();
  endtask

  task automatic test_commit_race();
    write_slot(1, 1'b1, 300, 30, 4, 4, 18'h6000, 1'b1);
    scan(30);
    px_none(300, 30, 1'b1);
    drain();
    frame();
    scan(30);
    px_obj(300, 30, 18'h6000);
    drain();
  endtask

  task automatic test_back_to_back_scan();
    int busy_cnt;
    write_slot(4, 1'b1, 400, 3, 4, 0, 18'h7100, 1'b0);
    write_slot(6, 1'b1, 420, 1020, 4, 10, 18'h7200, 1'b0);
    write_slot(7, 1'b1, 440, 3, 4, 4, 18'h7000, 1'b0);
    frame();
    tick();
    bus_if.line_start = 1'b1;
    bus_if.line_row   = 10'd3;
    tick();
    bus_if.line_start = 1'b0;
    tick();
    tick();
    bus_if.line_start = 1'b1;
    tick();
    bus_if.line_start = 1'b0;
    busy_cnt = 0;
    while (bus_if.scan_busy && busy_cnt < 40) begin
      busy_cnt++;
      tick();
    end
    n_total++;
    if (busy_cnt != NumObj) $display("FAIL restart_busy: got %0d cycles want %0d", busy_cnt, NumObj);
    else n_pass++;
    tick();
    tick();
    px_none(400, 3, 1'b1);
    px_none(421, 3, 1'b1);
    px_obj(441, 3, 18'h7001);
    px_none(441, 3, 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    tick();
    bus_if.col = 10'd440; bus_if.row = 10'd3; bus_if.video_on = 1'b1;
    bus_if.line_start = 1'b1; bus_if.line_row = 10'd3;
    tick();
    bus_if.line_start = 1'b0; bus_if.video_on = 1'b0;
    tick();
    tick();
    n_total++;
    if (bus_if.hit !== 1'b1 || bus_if.scan_busy !== 1'b1)
      $display("FAIL pre_reset_activity: got hit=%b busy=%b want 1 1", bus_if.hit, bus_if.scan_busy);
    else n_pass++;
    rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    frame();
    scan(3);
    px_none(440, 3, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_transparent();
    test_commit_race();
    test_back_to_back_scan();
    test_async_reset();
    n_total++;
    if (aq.size() != 0 || pq.size() != 0)
      $display("FAIL scoreboard_empty: got %0d/%0d pending want 0/0", aq.size(), pq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
